axis_variable_delay: RTL
========================

# axis_variable_delay

Runtime-programmable AXI4-Stream delay line with its own fill/lock sequencer. Samples are stored in an internal ring buffer. The block withholds output until the buffer holds `cfg_data` fresh samples, then runs lock-step with the stream so that every output beat is the input from exactly `cfg_data` transfers earlier. It sits on the ADC/DSP stream path wherever a delay must be retuned from the PS through a config register without reloading the bitstream.

## Interface
- `AXIS_TDATA_WIDTH`, 32, stream data width.
- `CNTR_WIDTH`, 10, ring buffer address width; depth is 2^CNTR_WIDTH; maximum delay is 2^CNTR_WIDTH−1.
- `aclk` in 1: single clock; all logic is on the rising edge.
- `aresetn` in 1: reset, synchronous, active-low.
- `cfg_data` in CNTR_WIDTH: requested delay D in transfers; may change at any time.
- `sts_data` out CNTR_WIDTH: current fill count.
- `sts_locked` out 1: high while in RUN.
- `s_axis_tready` out 1, `s_axis_tdata` in AXIS_TDATA_WIDTH, `s_axis_tvalid` in 1: slave stream.
- `m_axis_tready` in 1, `m_axis_tdata` out AXIS_TDATA_WIDTH, `m_axis_tvalid` out 1: master stream.

## Operation
- **Registers**
  - `cfg_reg`: latched delay.
  - `wr_ptr`: CNTR_WIDTH bits, wraps modulo 2^CNTR_WIDTH.
  - `fill_cnt`: CNTR_WIDTH bits.
  - `state`: FILL or RUN.
  - `mem`: 2^CNTR_WIDTH × AXIS_TDATA_WIDTH, combinational read.
- **Slave transfer:** `s_axis_tvalid & s_axis_tready`. On each one, `mem[wr_ptr] <= s_axis_tdata` and `wr_ptr <= wr_ptr+1`.
- **FILL state**
  - `s_axis_tready = (fill_cnt != cfg_reg)`.
  - `m_axis_tvalid = 0`; `m_axis_tdata = 0`.
  - Each slave transfer increments `fill_cnt`.
  - When `fill_cnt == cfg_reg` (registered compare), state becomes RUN on the next edge.
- **RUN state**
  - `s_axis_tready = m_axis_tready`; `m_axis_tvalid = s_axis_tvalid`.
  - `m_axis_tdata = mem[wr_ptr − cfg_reg]`, with modulo subtraction.
  - If `cfg_reg == 0`, `m_axis_tdata = s_axis_tdata` (pass-through, zero delay).
  - `fill_cnt` holds at `cfg_reg`.
- **Reconfiguration**
  - Any cycle with `cfg_data != cfg_reg` triggers a reconfiguration on the next edge: `cfg_reg <= cfg_data`, `fill_cnt <= 0`, state becomes FILL.
  - A transfer in the detecting cycle still completes under the old state and old delay, and still writes `mem` and advances `wr_ptr`.
  - That transfer is not counted toward the new fill. Reconfiguration has priority over the fill increment and over FILL→RUN.
- **Old samples:** the buffer is never cleared. Because `fill_cnt` restarts at 0, every output after relock comes from post-reconfiguration input only.
- **Outputs:** `sts_data = fill_cnt`; `sts_locked = (state == RUN)`.

## Timing
- **Reset** (`aresetn` low at an edge): `cfg_reg=0`, `fill_cnt=0`, `wr_ptr=0`, state FILL.
  - While in reset: `s_axis_tready=0`, `m_axis_tvalid=0`, `m_axis_tdata=0`, `sts_data=0`, `sts_locked=0`. `mem` is not reset.
  - Reset mid-stream discards all buffered data; behaviour afterwards is identical to power-up.
- **First cycle after reset release:** `cfg_reg=0` differs from `cfg_data` if the requested delay is nonzero, so reconfiguration starts on the next edge. Total relock takes D accepted transfers plus up to 2 cycles.
- **D=0 after reset:** FILL with `fill_cnt==cfg_reg`, so `s_axis_tready=0` for one cycle, then RUN.
- **Latency in RUN:** valid/ready/data are combinational, with zero cycles from `s_axis` to `m_axis`. The delay is counted in transfers, not clocks; stalls on either side do not change the sample offset.
- **Backpressure in RUN:** with `m_axis_tready=0`, no slave transfer occurs and `wr_ptr` and the output word are stable. AXI rule: once `m_axis_tvalid` is high, data holds until accepted, because `s_axis` must hold.
- **Full/empty:** FILL stops accepting exactly at `fill_cnt==D`. D=2^CNTR_WIDTH−1 is legal and reads the oldest unoverwritten entry. `wr_ptr` wrap needs no special handling.

## Test plan
- **Basic delay:** CNTR_WIDTH=4, cfg_data=4, ramp input 1,2,3… with continuous valid/ready.
  - `s_axis_tready` drops for one cycle after 4 transfers; `sts_data` reaches 4, then `sts_locked=1`.
  - Output beats in RUN are 1,2,3… aligned with input 5,6,7….
- **Zero delay:** cfg_data=0. After lock, `m_axis_tdata == s_axis_tdata` in the same cycle, and `m_axis_tvalid` follows `s_axis_tvalid`.
- **Random stalls:** cfg_data=3, random `s_axis_tvalid` and `m_axis_tready` at 50%. The scoreboard shows output k equals input k−3 for 1000 beats; data is stable while `m_axis_tready=0`.
- **Reconfiguration mid-stream:** running at D=4, change to D=2.
  - Next cycle `sts_locked=0` and `sts_data=0`.
  - After 2 new transfers it relocks, and each output equals the input from 2 transfers earlier, all post-change.
- **Maximum delay with wrap:** CNTR_WIDTH=4, D=15, 100-beat ramp. Output k equals input k−15 across multiple `wr_ptr` wraps.
- **Reset mid-RUN:** assert `aresetn=0` for 2 cycles during RUN.
  - All outputs are 0 during reset.
  - After release, FILL restarts from `sts_data=0`, and the first outputs are post-reset inputs only.

Source files
------------

// File: rtl/axis_variable_delay.sv
// AXI4-Stream delay line: a ring buffer with a fill/lock sequencer. Every output beat
// is the input from exactly cfg_data transfers earlier, retunable at runtime.
module axis_variable_delay #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNTR_WIDTH       = 10
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [CNTR_WIDTH-1:0]       cfg_data,
  output logic [CNTR_WIDTH-1:0]       sts_data,
  output logic                        sts_locked,
  output logic                        s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid
);

  localparam int DEPTH = 2 ** CNTR_WIDTH;

  typedef enum logic {FILL, RUN} state_t;

  state_t                      state_reg;
  logic [CNTR_WIDTH-1:0]       cfg_reg;
  logic [CNTR_WIDTH-1:0]       wr_ptr_reg;
  logic [CNTR_WIDTH-1:0]       fill_cnt_reg;
  logic [CNTR_WIDTH-1:0]       rd_addr;
  logic [AXIS_TDATA_WIDTH-1:0] mem [DEPTH];
  logic                        s_xfer;
  logic                        reconfig;
  logic                        fill_done;

  assign reconfig  = (cfg_data != cfg_reg);
  assign fill_done = (fill_cnt_reg == cfg_reg);
  // Modulo subtraction wraps naturally at the address width.
  assign rd_addr   = wr_ptr_reg - cfg_reg;

  // Outputs are forced low while aresetn is held, even before the first reset edge.
  always_comb begin
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    if (aresetn) begin
      if (state_reg == RUN) begin
        s_axis_tready = m_axis_tready;
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tdata  = (cfg_reg == '0) ? s_axis_tdata : mem[rd_addr];
      end else begin
        s_axis_tready = !fill_done;
      end
    end
  end

  assign s_xfer     = s_axis_tvalid & s_axis_tready;
  assign sts_data   = aresetn ? fill_cnt_reg : '0;
  assign sts_locked = aresetn & (state_reg == RUN);

  always_ff @(posedge aclk) begin
    if (s_xfer) begin
      mem[wr_ptr_reg] <= s_axis_tdata;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_reg    <= FILL;
      cfg_reg      <= '0;
      fill_cnt_reg <= '0;
      wr_ptr_reg   <= '0;
    end else begin
      if (s_xfer) begin
        wr_ptr_reg <= wr_ptr_reg + CNTR_WIDTH'(1);
      end
      // A new delay restarts the fill; the transfer in this cycle does not count toward it.
      if (reconfig) begin
        cfg_reg      <= cfg_data;
        fill_cnt_reg <= '0;
        state_reg    <= FILL;
      end else if (state_reg == FILL) begin
        if (fill_done) begin
          state_reg <= RUN;
        end else if (s_xfer) begin
          fill_cnt_reg <= fill_cnt_reg + CNTR_WIDTH'(1);
        end
      end
    end
  end

endmodule
